ysyx_22050133_axi_arbiter: RTL and testbench

//  2:1 arbiter between the I-cache and D-cache memory-side ports and the single AXI bridge port.

---
 rtl/ysyx_22050133_axi_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_22050133_axi_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_axi_arbiter.sv
// ysyx_22050133_axi_arbiter: 2:1 arbiter between the I-cache (m0) and D-cache (m1)
// memory-side ports and the single AXI bridge port. A granted master owns the bridge
// for its whole transaction (address phase plus len+1 data beats).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin contention resolution;
// otherwise m1 (D-cache) always wins contention.
module ysyx_22050133_axi_arbiter #(
    parameter int RW_DATA_WIDTH = 64,
    parameter int RW_ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     m0_addr_valid_i,
    output logic                     m0_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                     m0_we_i,
    input  logic [7:0]               m0_len_i,
    input  logic [2:0]               m0_size_i,
    input  logic [1:0]               m0_burst_i,
    input  logic                     m0_if_i,
    input  logic                     m0_w_data_valid_i,
    output logic                     m0_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] m0_w_data_i,
    output logic                     m0_r_data_valid_o,
    input  logic                     m0_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] m0_r_data_o,

    input  logic                     m1_addr_valid_i,
    output logic                     m1_addr_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                     m1_we_i,
    input  logic [7:0]               m1_len_i,
    input  logic [2:0]               m1_size_i,
    input  logic [1:0]               m1_burst_i,
    input  logic                     m1_if_i,
    input  logic                     m1_w_data_valid_i,
    output logic                     m1_w_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] m1_w_data_i,
    output logic                     m1_r_data_valid_o,
    input  logic                     m1_r_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] m1_r_data_o,

    output logic                     s_addr_valid_o,
    input  logic                     s_addr_ready_i,
    output logic [RW_ADDR_WIDTH-1:0] s_addr_o,
    output logic                     s_we_o,
    output logic [7:0]               s_len_o,
    output logic [2:0]               s_size_o,
    output logic [1:0]               s_burst_o,
    output logic                     s_if_o,
    output logic                     s_w_data_valid_o,
    input  logic                     s_w_data_ready_i,
    output logic [RW_DATA_WIDTH-1:0] s_w_data_o,
    input  logic                     s_r_data_valid_i,
    output logic                     s_r_data_ready_o,
    input  logic [RW_DATA_WIDTH-1:0] s_r_data_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       grant;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic       arb_pick;
    logic       any_req;
    logic       addr_hs;
    logic       w_hs;
    logic       r_hs;

    assign any_req = m0_addr_valid_i | m1_addr_valid_i;
    assign addr_hs = (state == S_ADDR)  & s_addr_valid_o   & s_addr_ready_i;
    assign w_hs    = (state == S_WDATA) & s_w_data_valid_o & s_w_data_ready_i;
    assign r_hs    = (state == S_RDATA) & s_r_data_valid_i & s_r_data_ready_o;

    // Arbitration decision: sole requester wins, contention follows the build-time rule
    always_comb begin
        arb_pick = m1_addr_valid_i;
        if (m0_addr_valid_i && m1_addr_valid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            arb_pick = ~last_grant;
`else
            arb_pick = 1'b1;
`endif
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, burst beat counter and last-served master
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                grant <= arb_pick;
            end
            if (addr_hs) begin
                beat_cnt <= s_len_o;
            end
            if (w_hs || r_hs) begin
                if (beat_cnt == 8'd0) begin
                    last_grant <= grant;
                end else begin
                    beat_cnt <= beat_cnt - 8'd1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (any_req) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (addr_hs) state_next = s_we_o ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (w_hs && beat_cnt == 8'd0) state_next = S_IDLE;
            end
            S_RDATA: begin
                if (r_hs && beat_cnt == 8'd0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output muxing: data always follows grant, handshakes only in the granted phase
    always_comb begin
        s_addr_o          = grant ? m1_addr_i   : m0_addr_i;
        s_we_o            = grant ? m1_we_i     : m0_we_i;
        s_len_o           = grant ? m1_len_i    : m0_len_i;
        s_size_o          = grant ? m1_size_i   : m0_size_i;
        s_burst_o         = grant ? m1_burst_i  : m0_burst_i;
        s_if_o            = grant ? m1_if_i     : m0_if_i;
        s_w_data_o        = grant ? m1_w_data_i : m0_w_data_i;
        m0_r_data_o       = s_r_data_i;
        m1_r_data_o       = s_r_data_i;
        s_addr_valid_o    = 1'b0;
        s_w_data_valid_o  = 1'b0;
        s_r_data_ready_o  = 1'b0;
        m0_addr_ready_o   = 1'b0;
        m1_addr_ready_o   = 1'b0;
        m0_w_data_ready_o = 1'b0;
        m1_w_data_ready_o = 1'b0;
        m0_r_data_valid_o = 1'b0;
        m1_r_data_valid_o = 1'b0;
        case (state)
            S_ADDR: begin
                s_addr_valid_o = grant ? m1_addr_valid_i : m0_addr_valid_i;
                if (grant) m1_addr_ready_o = s_addr_ready_i;
                else       m0_addr_ready_o = s_addr_ready_i;
            end
            S_WDATA: begin
                s_w_data_valid_o = grant ? m1_w_data_valid_i : m0_w_data_valid_i;
                if (grant) m1_w_data_ready_o = s_w_data_ready_i;
                else       m0_w_data_ready_o = s_w_data_ready_i;
            end
            S_RDATA: begin
                s_r_data_ready_o = grant ? m1_r_data_ready_i : m0_r_data_ready_i;
                if (grant) m1_r_data_valid_o = s_r_data_valid_i;
                else       m0_r_data_valid_o = s_r_data_valid_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// Directed bench for ysyx_22050133_axi_arbiter with queue-based scoreboards for
// address, write-beat and read-beat traffic. Honours ARB_ROUND_ROBIN_EN like the RTL.
module tb_ysyx_22050133_axi_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_addr_valid_i, m0_addr_ready_o, m0_we_i, m0_if_i;
    logic [31:0] m0_addr_i;
    logic [7:0]  m0_len_i;
    logic [2:0]  m0_size_i;
    logic [1:0]  m0_burst_i;
    logic        m0_w_data_valid_i, m0_w_data_ready_o, m0_r_data_valid_o, m0_r_data_ready_i;
    logic [63:0] m0_w_data_i, m0_r_data_o;
    logic        m1_addr_valid_i, m1_addr_ready_o, m1_we_i, m1_if_i;
    logic [31:0] m1_addr_i;
    logic [7:0]  m1_len_i;
    logic [2:0]  m1_size_i;
    logic [1:0]  m1_burst_i;
    logic        m1_w_data_valid_i, m1_w_data_ready_o, m1_r_data_valid_o, m1_r_data_ready_i;
    logic [63:0] m1_w_data_i, m1_r_data_o;
    logic        s_addr_valid_o, s_addr_ready_i, s_we_o, s_if_o;
    logic [31:0] s_addr_o;
    logic [7:0]  s_len_o;
    logic [2:0]  s_size_o;
    logic [1:0]  s_burst_o;
    logic        s_w_data_valid_o, s_w_data_ready_i, s_r_data_valid_i, s_r_data_ready_o;
    logic [63:0] s_w_data_o, s_r_data_i;

    ysyx_22050133_axi_arbiter #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_valid_i(m0_addr_valid_i), .m0_addr_ready_o(m0_addr_ready_o), .m0_addr_i(m0_addr_i),
        .m0_we_i(m0_we_i), .m0_len_i(m0_len_i), .m0_size_i(m0_size_i), .m0_burst_i(m0_burst_i),
        .m0_if_i(m0_if_i), .m0_w_data_valid_i(m0_w_data_valid_i), .m0_w_data_ready_o(m0_w_data_ready_o),
        .m0_w_data_i(m0_w_data_i), .m0_r_data_valid_o(m0_r_data_valid_o),
        .m0_r_data_ready_i(m0_r_data_ready_i), .m0_r_data_o(m0_r_data_o),
        .m1_addr_valid_i(m1_addr_valid_i), .m1_addr_ready_o(m1_addr_ready_o), .m1_addr_i(m1_addr_i),
        .m1_we_i(m1_we_i), .m1_len_i(m1_len_i), .m1_size_i(m1_size_i), .m1_burst_i(m1_burst_i),
        .m1_if_i(m1_if_i), .m1_w_data_valid_i(m1_w_data_valid_i), .m1_w_data_ready_o(m1_w_data_ready_o),
        .m1_w_data_i(m1_w_data_i), .m1_r_data_valid_o(m1_r_data_valid_o),
        .m1_r_data_ready_i(m1_r_data_ready_i), .m1_r_data_o(m1_r_data_o),
        .s_addr_valid_o(s_addr_valid_o), .s_addr_ready_i(s_addr_ready_i), .s_addr_o(s_addr_o),
        .s_we_o(s_we_o), .s_len_o(s_len_o), .s_size_o(s_size_o), .s_burst_o(s_burst_o), .s_if_o(s_if_o),
        .s_w_data_valid_o(s_w_data_valid_o), .s_w_data_ready_i(s_w_data_ready_i), .s_w_data_o(s_w_data_o),
        .s_r_data_valid_i(s_r_data_valid_i), .s_r_data_ready_o(s_r_data_ready_o), .s_r_data_i(s_r_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  len;
    } areq_t;

    typedef struct {
        logic        m;
        logic [63:0] d;
    } rbeat_t;

    areq_t       aq[$];
    rbeat_t      rq[$];
    logic [63:0] wq[$];

    int checks = 0;
    int fails  = 0;
    int a_hs   = 0;
    int w_hs   = 0;
    int r_hs   = 0;

    logic [8:0] all_vr;
    assign all_vr = {m0_addr_ready_o, m1_addr_ready_o, m0_w_data_ready_o, m1_w_data_ready_o,
                     m0_r_data_valid_o, m1_r_data_valid_o, s_addr_valid_o, s_w_data_valid_o,
                     s_r_data_ready_o};

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, called once per cycle at the falling edge
    task automatic monitor();
        areq_t  a;
        rbeat_t r;
        chk("addr_ready_exclusive", {63'd0, m0_addr_ready_o & m1_addr_ready_o}, 64'd0);
        chk("r_data_fanout", m1_r_data_o ^ m0_r_data_o, 64'd0);
        if (s_addr_valid_o && s_addr_ready_i) begin
            a_hs++;
            chk("addr_expected", {63'd0, aq.size() != 0}, 64'd1);
            if (aq.size() != 0) begin
                a = aq.pop_front();
                chk("addr_value", {32'd0, s_addr_o}, {32'd0, a.addr});
                chk("addr_we", {63'd0, s_we_o}, {63'd0, a.we});
                chk("addr_len", {56'd0, s_len_o}, {56'd0, a.len});
            end
        end
        if (s_w_data_valid_o && s_w_data_ready_i) begin
            w_hs++;
            chk("w_expected", {63'd0, wq.size() != 0}, 64'd1);
            if (wq.size() != 0) chk("w_data", s_w_data_o, wq.pop_front());
        end
        if ((m0_r_data_valid_o && m0_r_data_ready_i) || (m1_r_data_valid_o && m1_r_data_ready_i)) begin
            r_hs++;
            chk("r_expected", {63'd0, rq.size() != 0}, 64'd1);
            if (rq.size() != 0) begin
                r = rq.pop_front();
                chk("r_master", {63'd0, m1_r_data_valid_o}, {63'd0, r.m});
                chk("r_data", r.m ? m1_r_data_o : m0_r_data_o, r.d);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_addr_valid_i = 0; m0_addr_i = '0; m0_we_i = 0; m0_len_i = '0; m0_size_i = 3'd3;
        m0_burst_i = 2'd1; m0_if_i = 1; m0_w_data_valid_i = 0; m0_w_data_i = '0; m0_r_data_ready_i = 0;
        m1_addr_valid_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_len_i = '0; m1_size_i = 3'd3;
        m1_burst_i = 2'd1; m1_if_i = 0; m1_w_data_valid_i = 0; m1_w_data_i = '0; m1_r_data_ready_i = 0;
        s_addr_ready_i = 0; s_w_data_ready_i = 0; s_r_data_valid_i = 0; s_r_data_i = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        chk("reset_vr", {55'd0, all_vr}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Bridge answers address and read beats; masters drop addr_valid once accepted
    task automatic serve(input logic [63:0] base, input int n, input int budget);
        int  r0;
        logic drop0, drop1, done;
        r0 = r_hs;
        s_addr_ready_i = 1; s_r_data_valid_i = 1; m0_r_data_ready_i = 1; m1_r_data_ready_i = 1;
        for (int c = 0; c < budget; c++) begin
            s_r_data_i = base + 64'(r_hs - r0);
            sample();
            drop0 = m0_addr_valid_i && m0_addr_ready_o;
            drop1 = m1_addr_valid_i && m1_addr_ready_o;
            done  = (r_hs - r0) == n;
            advance();
            if (drop0) m0_addr_valid_i = 0;
            if (drop1) m1_addr_valid_i = 0;
            if (done) break;
        end
        s_r_data_valid_i = 0;
        chk("serve_beats", 64'(r_hs - r0), 64'(n));
    endtask

    initial begin
        int a0, w0, r0, k;
        logic hs;
        logic first;
        rst = 1'b1;
        clear_inputs();
        #2;
        apply_reset();

        // 1: m0 read len=7, eight beats 0x10..0x17
        a0 = a_hs; r0 = r_hs;
        m0_addr_valid_i = 1; m0_addr_i = 32'h8000_0000; m0_we_i = 0; m0_len_i = 8'd7;
        s_addr_ready_i = 1;
        aq.push_back('{32'h8000_0000, 1'b0, 8'd7});
        sample();
        chk("t1_arb_cycle", {63'd0, s_addr_valid_o}, 64'd0);
        advance();
        sample();
        chk("t1_m0_addr_ready", {63'd0, m0_addr_ready_o}, 64'd1);
        chk("t1_m1_addr_ready", {63'd0, m1_addr_ready_o}, 64'd0);
        advance();
        m0_addr_valid_i = 0; m0_r_data_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            s_r_data_valid_i = 1; s_r_data_i = 64'h10 + 64'(i);
            rq.push_back('{1'b0, 64'h10 + 64'(i)});
            sample();
            chk("t1_m1_r_valid", {63'd0, m1_r_data_valid_o}, 64'd0);
            advance();
        end
        s_r_data_valid_i = 0;
        sample();
        chk("t1_idle_vr", {55'd0, all_vr}, 64'd0);
        chk("t1_beats", 64'(r_hs - r0), 64'd8);
        chk("t1_addr_hs", 64'(a_hs - a0), 64'd1);
        advance();
        m0_r_data_ready_i = 0;

        // 2: m1 write len=7, bridge w_ready toggles
        w0 = w_hs;
        m1_addr_valid_i = 1; m1_addr_i = 32'h0000_1000; m1_we_i = 1; m1_len_i = 8'd7;
        aq.push_back('{32'h0000_1000, 1'b1, 8'd7});
        sample();
        chk("t2_arb_cycle", {63'd0, s_addr_valid_o}, 64'd0);
        advance();
        sample();
        chk("t2_m1_addr_ready", {63'd0, m1_addr_ready_o}, 64'd1);
        chk("t2_m0_addr_ready", {63'd0, m0_addr_ready_o}, 64'd0);
        advance();
        m1_addr_valid_i = 0;
        k = 0;
        m1_w_data_valid_i = 1; m1_w_data_i = 64'hA5A5_0000_0000_0000;
        wq.push_back(64'hA5A5_0000_0000_0000);
        for (int c = 0; c < 40; c++) begin
            s_w_data_ready_i = (c % 2) == 0;
            sample();
            hs = m1_w_data_valid_i && m1_w_data_ready_o;
            advance();
            if (hs) begin
                k++;
                if (k == 8) begin
                    m1_w_data_valid_i = 0;
                    break;
                end
                m1_w_data_i = 64'hA5A5_0000_0000_0000 + 64'(k);
                wq.push_back(64'hA5A5_0000_0000_0000 + 64'(k));
            end
        end
        m1_w_data_valid_i = 0;
        s_w_data_ready_i = 1;
        sample();
        chk("t2_idle_w_ready", {63'd0, m1_w_data_ready_o}, 64'd0);
        chk("t2_w_beats", 64'(w_hs - w0), 64'd8);
        advance();
        s_w_data_ready_i = 0;

        // 3: simultaneous len=0 reads after reset
        apply_reset();
        a0 = a_hs;
        first = RR ? 1'b0 : 1'b1;
        m0_addr_valid_i = 1; m0_addr_i = 32'h100; m0_we_i = 0; m0_len_i = 0;
        m1_addr_valid_i = 1; m1_addr_i = 32'h200; m1_we_i = 0; m1_len_i = 0;
        aq.push_back('{first ? 32'h200 : 32'h100, 1'b0, 8'd0});
        aq.push_back('{first ? 32'h100 : 32'h200, 1'b0, 8'd0});
        rq.push_back('{first, 64'hD0});
        rq.push_back('{~first, 64'hD1});
        serve(64'hD0, 2, 20);
        chk("t3_addr_hs", 64'(a_hs - a0), 64'd2);

        // 4: m1 request during m0 burst
        r0 = r_hs;
        m0_addr_valid_i = 1; m0_addr_i = 32'h400; m0_we_i = 0; m0_len_i = 8'd7;
        s_addr_ready_i = 1; m0_r_data_ready_i = 1; m1_r_data_ready_i = 1;
        aq.push_back('{32'h400, 1'b0, 8'd7});
        sample();
        advance();
        sample();
        chk("t4_m0_addr_ready", {63'd0, m0_addr_ready_o}, 64'd1);
        advance();
        m0_addr_valid_i = 0;
        for (int i = 0; i < 8; i++) begin
            s_r_data_valid_i = 1; s_r_data_i = 64'h40 + 64'(i);
            rq.push_back('{1'b0, 64'h40 + 64'(i)});
            if (i == 3) begin
                m1_addr_valid_i = 1; m1_addr_i = 32'h300; m1_we_i = 0; m1_len_i = 0;
                aq.push_back('{32'h300, 1'b0, 8'd0});
            end
            sample();
            chk("t4_m0_beat_valid", {63'd0, m0_r_data_valid_o}, 64'd1);
            chk("t4_no_addr", {63'd0, s_addr_valid_o}, 64'd0);
            advance();
        end
        s_r_data_valid_i = 0;
        sample();
        chk("t4_idle_vr", {55'd0, all_vr}, 64'd0);
        advance();
        sample();
        chk("t4_m1_addr_valid", {63'd0, s_addr_valid_o}, 64'd1);
        chk("t4_m1_addr", {32'd0, s_addr_o}, 64'h300);
        advance();
        m1_addr_valid_i = 0;
        s_r_data_valid_i = 1; s_r_data_i = 64'h77;
        rq.push_back('{1'b1, 64'h77});
        sample();
        advance();
        s_r_data_valid_i = 0;
        chk("t4_beats", 64'(r_hs - r0), 64'd9);

        // 5: asynchronous reset during write beat 4
        m0_addr_valid_i = 1; m0_addr_i = 32'h500; m0_we_i = 1; m0_len_i = 8'd7;
        s_addr_ready_i = 1; s_w_data_ready_i = 1;
        aq.push_back('{32'h500, 1'b1, 8'd7});
        sample();
        advance();
        sample();
        advance();
        m0_addr_valid_i = 0; m0_w_data_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            m0_w_data_i = 64'h5500 + 64'(i);
            wq.push_back(64'h5500 + 64'(i));
            sample();
            advance();
        end
        m0_w_data_i = 64'h5504;
        #2;
        chk("t5_pre_reset_w", {63'd0, s_w_data_valid_o & m0_w_data_ready_o}, 64'd1);
        rst = 1'b0;
        #1;
        chk("t5_async_reset_vr", {55'd0, all_vr}, 64'd0);
        wq.delete();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        a0 = a_hs;
        m0_addr_valid_i = 1; m0_addr_i = 32'h600; m0_we_i = 0; m0_len_i = 0;
        aq.push_back('{32'h600, 1'b0, 8'd0});
        rq.push_back('{1'b0, 64'h66});
        serve(64'h66, 1, 10);
        chk("t5_addr_hs", 64'(a_hs - a0), 64'd1);

        // 6: bridge stalls the address phase
        m0_addr_valid_i = 1; m0_addr_i = 32'h700; m0_we_i = 0; m0_len_i = 0;
        m1_addr_valid_i = 1; m1_addr_i = 32'h800; m1_we_i = 0; m1_len_i = 0;
        s_addr_ready_i = 0;
        sample();
        advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t6_m1_addr_ready", {63'd0, m1_addr_ready_o}, 64'd0);
            chk("t6_m0_addr_ready", {63'd0, m0_addr_ready_o}, 64'd0);
            chk("t6_addr_valid", {63'd0, s_addr_valid_o}, 64'd1);
            chk("t6_addr_held", {32'd0, s_addr_o}, 64'h800);
            advance();
        end
        aq.push_back('{32'h800, 1'b0, 8'd0});
        aq.push_back('{32'h700, 1'b0, 8'd0});
        rq.push_back('{1'b1, 64'h90});
        rq.push_back('{1'b0, 64'h91});
        serve(64'h90, 2, 20);

        chk("end_aq_empty", 64'(aq.size()), 64'd0);
        chk("end_rq_empty", 64'(rq.size()), 64'd0);
        chk("end_wq_empty", 64'(wq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
